// File: rtl/rv_pkg.sv
// Shared RV32I core types and sizes.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage : rv_pkg

// File: rtl/rv_regfile.sv
// RV32I integer register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero with no backing storage.
module rv_regfile
    import rv_pkg::*;
#(
    parameter int unsigned DATA_W = XLEN,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [ADDR_W-1:0] regA_sel,
    input  logic [ADDR_W-1:0] regB_sel,
    input  logic [ADDR_W-1:0] regW_sel,
    input  logic [DATA_W-1:0] regW_i,
    output logic [DATA_W-1:0] regA_o,
    output logic [DATA_W-1:0] regB_o
);

    localparam int unsigned NUM_R = 1 << ADDR_W;

    // x1..x(NUM_R-1); index 0 is decoded away on both read and write.
    logic [DATA_W-1:0] regs_q [1:NUM_R-1] = '{default: '0};
    logic [DATA_W-1:0] regs_d [1:NUM_R-1];

    // Next-state: a single enabled write lands in its register; writes to x0 match nothing.
    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 1; i < NUM_R; i++) begin
            if (wen && (regW_sel == ADDR_W'(i))) begin
                regs_d[i] = regW_i;
            end
        end
    end

    // Storage update; reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < NUM_R; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port A: zero-latency mux, index 0 reads zero; no write bypass.
    always_comb begin
        regA_o = '0;
        for (int unsigned i = 1; i < NUM_R; i++) begin
            if (regA_sel == ADDR_W'(i)) begin
                regA_o = regs_q[i];
            end
        end
    end

    // Read port B: identical to port A.
    always_comb begin
        regB_o = '0;
        for (int unsigned i = 1; i < NUM_R; i++) begin
            if (regB_sel == ADDR_W'(i)) begin
                regB_o = regs_q[i];
            end
        end
    end

endmodule : rv_regfile

// File: tb/tb_rv_regfile.sv
// Self-checking bench for rv_regfile: behavioural array model, per-cycle
// comparison of both read ports, directed literal checks and random traffic.
`timescale 1ps/1ps
module tb_rv_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wen = 1'b0;
    logic [4:0]  regA_sel = '0;
    logic [4:0]  regB_sel = '0;
    logic [4:0]  regW_sel = '0;
    logic [31:0] regW_i = '0;
    logic [31:0] regA_o;
    logic [31:0] regB_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Architectural view of the register file: plain array, x0 never written.
    logic [31:0] mem [32];
    logic [31:0] fill_val [32];

    rv_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .wen      (wen),
        .regA_sel (regA_sel),
        .regB_sel (regB_sel),
        .regW_sel (regW_sel),
        .regW_i   (regW_i),
        .regA_o   (regA_o),
        .regB_o   (regB_o)
    );

    always #5000 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : mem[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Model update at each rising edge from the values the DUT samples.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        end else if (wen && regW_sel != 5'd0) begin
            mem[regW_sel] = regW_i;
        end
    end

    // Continuous comparison of both ports against the model, mid-cycle.
    always @(negedge clk) begin
        check("cyc_portA", regA_o, model_read(regA_sel));
        check("cyc_portB", regB_o, model_read(regB_sel));
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;

        // Power-up, before any edge.
        #10;
        check("powerup_A", regA_o, 32'h0);
        check("powerup_B", regB_o, 32'h0);

        // Fill all indices with random data.
        for (int i = 0; i < 32; i++) fill_val[i] = (i == 0) ? 32'h0 : $urandom;
        tick();
        for (int i = 0; i < 32; i++) begin
            wen = 1'b1;
            regW_sel = 5'(i);
            regW_i = (i == 0) ? 32'h0 : fill_val[i];
            tick();
        end
        wen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            regA_sel = 5'(i);
            regB_sel = 5'(i);
            #1;
            check("fill_A", regA_o, fill_val[i]);
            check("fill_B", regB_o, fill_val[i]);
        end

        // Write to x0 must be ignored.
        wen = 1'b1; regW_sel = 5'd0; regW_i = 32'hDEADBEEF;
        tick();
        wen = 1'b0; regA_sel = 5'd0;
        #1;
        check("x0_write", regA_o, 32'h0);

        // Dual-port reads and write-enable gating.
        wen = 1'b1; regW_sel = 5'd5; regW_i = 32'h1234_5678;
        tick();
        regW_sel = 5'd6; regW_i = 32'hCAFE_F00D;
        tick();
        wen = 1'b0; regA_sel = 5'd5; regB_sel = 5'd6;
        #1;
        check("dual_A", regA_o, 32'h1234_5678);
        check("dual_B", regB_o, 32'hCAFE_F00D);
        regW_sel = 5'd5; regW_i = 32'hFFFF_FFFF;
        tick();
        check("wen_gate", regA_o, 32'h1234_5678);

        // Read during write to the same index: old value until the edge.
        wen = 1'b1; regW_sel = 5'd7; regW_i = 32'hA; regA_sel = 5'd7;
        tick();
        regW_i = 32'hB;
        @(negedge clk);
        #1;
        check("rdw_before", regA_o, 32'hA);
        @(posedge clk);
        #1;
        check("rdw_after", regA_o, 32'hB);
        #1;
        wen = 1'b0;

        // Reset mid-operation with a competing write to x3.
        wen = 1'b1; regW_sel = 5'd3; regW_i = 32'h77;
        tick();
        rst = 1'b1; regW_i = 32'h55;
        tick();
        for (int i = 0; i < 32; i++) begin
            regA_sel = 5'(i);
            regB_sel = 5'(31 - i);
            #1;
            check("rst_A", regA_o, 32'h0);
            check("rst_B", regB_o, 32'h0);
        end
        rst = 1'b0; wen = 1'b1; regW_sel = 5'd3; regW_i = 32'h55;
        tick();
        wen = 1'b0; regA_sel = 5'd3;
        #1;
        check("post_rst_x3", regA_o, 32'h55);

        // Random traffic, checked every cycle by the compare process.
        for (int c = 0; c < 400; c++) begin
            rst      = ($urandom_range(0, 59) == 0);
            wen      = $urandom_range(0, 1) == 1;
            regW_sel = 5'($urandom_range(0, 31));
            regW_i   = $urandom;
            regA_sel = 5'($urandom_range(0, 31));
            regB_sel = ($urandom_range(0, 3) == 0) ? regA_sel : 5'($urandom_range(0, 31));
            tick();
            // Random mid-cycle select change: read path must follow at once.
            regA_sel = 5'($urandom_range(0, 31));
            #1;
            check("rand_sel_A", regA_o, model_read(regA_sel));
        end
        rst = 1'b0; wen = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rv_regfile
